// File: rtl/noc_hdr_enc.sv
// noc_hdr_enc: source-side packet injector for the SDM NoC network interface.
// Converts an absolute destination into the relative, digit-encoded XY hop
// address, then emits it as a head flit followed by the payload flits.
// Head flit: [7:0] X byte, [15:8] Y byte, [16] X sign, [17] Y sign, rest zero.
// Each byte is {onehot(mag/4), onehot(mag%4)}. Routers decrement it one hop
// at a time.
module noc_hdr_enc #(
  parameter int DW = 32,
  parameter int LX = 0,
  parameter int LY = 0
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          req_vld,
  output logic          req_rdy,
  input  logic [3:0]    req_x,
  input  logic [3:0]    req_y,
  input  logic [3:0]    req_len,
  input  logic [DW-1:0] pl_data,
  input  logic          pl_vld,
  output logic          pl_rdy,
  output logic [DW-1:0] fo_data,
  output logic [1:0]    fo_type,
  output logic          fo_vld,
  input  logic          fo_rdy
);

  localparam logic [3:0] LOC_X = 4'(LX);
  localparam logic [3:0] LOC_Y = 4'(LY);

  localparam logic [1:0] T_BODY   = 2'b00;
  localparam logic [1:0] T_TAIL   = 2'b01;
  localparam logic [1:0] T_HEAD   = 2'b10;
  localparam logic [1:0] T_SINGLE = 2'b11;

  typedef enum logic [1:0] {
    S_IDLE,
    S_HEAD,
    S_BODY
  } state_t;

  // Digit encoding of a 0..15 hop count: high digit one-hot in the upper
  // nibble, low digit one-hot in the lower nibble.
  function automatic logic [7:0] enc_hops(input logic [3:0] mag);
    logic [3:0] hi_oh;
    logic [3:0] lo_oh;
    hi_oh = 4'b0001 << mag[3:2];
    lo_oh = 4'b0001 << mag[1:0];
    return {hi_oh, lo_oh};
  endfunction

  state_t        r_state;
  logic [3:0]    r_rem;
  logic [DW-1:0] r_fo_data;
  logic [1:0]    r_fo_type;
  logic          r_fo_vld;

  state_t        w_state_nxt;
  logic [3:0]    w_rem_nxt;
  logic [DW-1:0] w_data_nxt;
  logic [1:0]    w_type_nxt;
  logic          w_vld_nxt;
  logic          w_req_rdy;
  logic          w_pl_rdy;

  logic          w_x_neg;
  logic          w_y_neg;
  logic [3:0]    w_x_mag;
  logic [3:0]    w_y_mag;
  logic [DW-1:0] w_head;

  // Relative hop magnitudes and direction signs, assembled into the head flit.
  always_comb begin
    w_x_neg = (req_x < LOC_X);
    w_y_neg = (req_y < LOC_Y);
    w_x_mag = w_x_neg ? (LOC_X - req_x) : (req_x - LOC_X);
    w_y_mag = w_y_neg ? (LOC_Y - req_y) : (req_y - LOC_Y);
    w_head        = '0;
    w_head[7:0]   = enc_hops(w_x_mag);
    w_head[15:8]  = enc_hops(w_y_mag);
    w_head[16]    = w_x_neg;
    w_head[17]    = w_y_neg;
  end

  // Next-state and output-register load decisions for the packet sequencer.
  always_comb begin
    // NOTE: every signal gets a default first so no path can infer a latch.
    w_state_nxt = r_state;
    w_rem_nxt   = r_rem;
    w_data_nxt  = r_fo_data;
    w_type_nxt  = r_fo_type;
    w_vld_nxt   = r_fo_vld;
    w_req_rdy   = 1'b0;
    w_pl_rdy    = 1'b0;

    unique case (r_state)
      S_IDLE: begin
        w_req_rdy = 1'b1;
        if (req_vld) begin
          w_data_nxt  = w_head;
          w_type_nxt  = (req_len == 4'd0) ? T_SINGLE : T_HEAD;
          w_vld_nxt   = 1'b1;
          w_rem_nxt   = req_len;
          w_state_nxt = S_HEAD;
        end
      end

      S_HEAD: begin
        // The head is always valid here, so a consumed head can be replaced
        // by the first payload flit in the same cycle.
        w_pl_rdy = fo_rdy && (r_rem != 4'd0);
        if (fo_rdy) begin
          if (r_rem == 4'd0) begin
            w_vld_nxt   = 1'b0;
            w_state_nxt = S_IDLE;
          end else begin
            w_state_nxt = S_BODY;
            if (pl_vld) begin
              w_data_nxt = pl_data;
              w_type_nxt = (r_rem == 4'd1) ? T_TAIL : T_BODY;
              w_vld_nxt  = 1'b1;
              w_rem_nxt  = r_rem - 4'd1;
            end else begin
              w_vld_nxt = 1'b0;
            end
          end
        end
      end

      S_BODY: begin
        w_pl_rdy = (r_rem != 4'd0) && (!r_fo_vld || fo_rdy);
        if (w_pl_rdy && pl_vld) begin
          w_data_nxt = pl_data;
          w_type_nxt = (r_rem == 4'd1) ? T_TAIL : T_BODY;
          w_vld_nxt  = 1'b1;
          w_rem_nxt  = r_rem - 4'd1;
        end else if (r_fo_vld && fo_rdy) begin
          w_vld_nxt = 1'b0;
          // Nothing left to load means the flit just consumed was the tail.
          if (r_rem == 4'd0) begin
            w_state_nxt = S_IDLE;
          end
        end
      end

      default: begin
        w_state_nxt = S_IDLE;
        w_vld_nxt   = 1'b0;
      end
    endcase
  end

  // State, remaining-payload counter and output flit register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= S_IDLE;
      r_rem     <= 4'd0;
      r_fo_data <= '0;
      r_fo_type <= T_BODY;
      r_fo_vld  <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments keep every register updating from
      // pre-edge values, independent of statement order.
      r_state   <= w_state_nxt;
      r_rem     <= w_rem_nxt;
      r_fo_data <= w_data_nxt;
      r_fo_type <= w_type_nxt;
      r_fo_vld  <= w_vld_nxt;
    end
  end

  assign req_rdy = w_req_rdy;
  assign pl_rdy  = w_pl_rdy;
  assign fo_data = r_fo_data;
  assign fo_type = r_fo_type;
  assign fo_vld  = r_fo_vld;

endmodule

// File: tb/tb_noc_hdr_enc.sv
// Testbench for noc_hdr_enc: directed requests and payloads with hand-computed
// expected flits queued per instance; monitors pop and compare on each
// output handshake.
module tb_noc_hdr_enc;

  typedef struct packed {
    logic [31:0] data;
    logic [1:0]  typ;
  } flit_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n;

  // Main instance: local (5,5).
  logic        req_vld, req_rdy, pl_vld, pl_rdy, fo_vld, fo_rdy;
  logic [3:0]  req_x, req_y, req_len;
  logic [31:0] pl_data, fo_data;
  logic [1:0]  fo_type;

  // Corner instances: local (0,0) and (15,15), always ready on the output.
  logic        req_vld0, req_rdy0, pl_rdy0, fo_vld0;
  logic [3:0]  req_x0, req_y0;
  logic [31:0] fo_data0;
  logic [1:0]  fo_type0;
  logic        req_vldf, req_rdyf, pl_rdyf, fo_vldf;
  logic [3:0]  req_xf, req_yf;
  logic [31:0] fo_dataf;
  logic [1:0]  fo_typef;

  noc_hdr_enc #(.DW(32), .LX(5), .LY(5)) u_dut (
    .clk(clk), .rst_n(rst_n),
    .req_vld(req_vld), .req_rdy(req_rdy),
    .req_x(req_x), .req_y(req_y), .req_len(req_len),
    .pl_data(pl_data), .pl_vld(pl_vld), .pl_rdy(pl_rdy),
    .fo_data(fo_data), .fo_type(fo_type), .fo_vld(fo_vld), .fo_rdy(fo_rdy)
  );

  noc_hdr_enc #(.DW(32), .LX(0), .LY(0)) u_dut0 (
    .clk(clk), .rst_n(rst_n),
    .req_vld(req_vld0), .req_rdy(req_rdy0),
    .req_x(req_x0), .req_y(req_y0), .req_len(4'd0),
    .pl_data(32'd0), .pl_vld(1'b0), .pl_rdy(pl_rdy0),
    .fo_data(fo_data0), .fo_type(fo_type0), .fo_vld(fo_vld0), .fo_rdy(1'b1)
  );

  noc_hdr_enc #(.DW(32), .LX(15), .LY(15)) u_dutf (
    .clk(clk), .rst_n(rst_n),
    .req_vld(req_vldf), .req_rdy(req_rdyf),
    .req_x(req_xf), .req_y(req_yf), .req_len(4'd0),
    .pl_data(32'd0), .pl_vld(1'b0), .pl_rdy(pl_rdyf),
    .fo_data(fo_dataf), .fo_type(fo_typef), .fo_vld(fo_vldf), .fo_rdy(1'b1)
  );

  flit_t q5[$];
  flit_t q0[$];
  flit_t qf[$];
  int    pop_cyc[$];
  int    n_pop  = 0;
  int    cyc    = 0;
  int    errors = 0;
  int    checks = 0;
  bit    rdy_rand = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // Output-ready driver: always ready, or pseudo-random during backpressure.
  initial begin
    fo_rdy = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      fo_rdy = rdy_rand ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  // Main-instance monitor: scoreboard pops, stall stability, pl_rdy gating.
  initial begin : mon_main
    flit_t       e;
    logic        stalled;
    logic [31:0] st_data;
    logic [1:0]  st_type;
    stalled = 1'b0;
    st_data = '0;
    st_type = '0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        stalled = 1'b0;
      end else begin
        if (stalled) begin
          check("stall_vld", 64'(fo_vld), 64'd1);
          check("stall_data", 64'(fo_data), 64'(st_data));
          check("stall_type", 64'(fo_type), 64'(st_type));
        end
        if (fo_vld && !fo_rdy) begin
          check("pl_rdy_in_stall", 64'(pl_rdy), 64'd0);
          stalled = 1'b1;
          st_data = fo_data;
          st_type = fo_type;
        end else begin
          stalled = 1'b0;
        end
        if (fo_vld && fo_rdy) begin
          check("flit_expected", 64'(q5.size() != 0), 64'd1);
          if (q5.size() != 0) begin
            e = q5.pop_front();
            check("flit_data", 64'(fo_data), 64'(e.data));
            check("flit_type", 64'(fo_type), 64'(e.typ));
          end
          pop_cyc.push_back(cyc);
          n_pop++;
        end
      end
    end
  end

  // Corner-instance monitors.
  initial begin : mon_corner
    flit_t e;
    forever begin
      @(negedge clk);
      if (rst_n && fo_vld0) begin
        check("c0_expected", 64'(q0.size() != 0), 64'd1);
        if (q0.size() != 0) begin
          e = q0.pop_front();
          check("c0_data", 64'(fo_data0), 64'(e.data));
          check("c0_type", 64'(fo_type0), 64'(e.typ));
        end
      end
      if (rst_n && fo_vldf) begin
        check("cf_expected", 64'(qf.size() != 0), 64'd1);
        if (qf.size() != 0) begin
          e = qf.pop_front();
          check("cf_data", 64'(fo_dataf), 64'(e.data));
          check("cf_type", 64'(fo_typef), 64'(e.typ));
        end
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  task automatic send_req(input logic [3:0] x, input logic [3:0] y,
                          input logic [3:0] len, input logic [31:0] hd);
    int    n;
    flit_t f;
    f.data = hd;
    f.typ  = (len == 4'd0) ? 2'b11 : 2'b10;
    q5.push_back(f);
    req_x   = x;
    req_y   = y;
    req_len = len;
    req_vld = 1'b1;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!req_rdy && n < 50);
    check("req_accept", 64'(req_rdy), 64'd1);
    @(posedge clk);
    #1;
    req_vld = 1'b0;
    req_x   = 4'($urandom);
    req_y   = 4'($urandom);
    req_len = 4'($urandom);
  endtask

  task automatic send_pl(input logic [31:0] d, input logic [1:0] typ, input int gap);
    int    n;
    flit_t f;
    repeat (gap) begin
      @(posedge clk);
      #1;
    end
    f.data = d;
    f.typ  = typ;
    q5.push_back(f);
    pl_data = d;
    pl_vld  = 1'b1;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!pl_rdy && n < 100);
    check("pl_accept", 64'(pl_rdy), 64'd1);
    @(posedge clk);
    #1;
    pl_vld  = 1'b0;
    pl_data = $urandom;
  endtask

  task automatic drain(input int budget);
    int n;
    n = 0;
    while (q5.size() != 0 && n < budget) begin
      @(posedge clk);
      #1;
      n++;
    end
    check("drain", 64'(q5.size()), 64'd0);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_fo_vld"}, 64'(fo_vld), 64'd0);
    check({tag, "_fo_data"}, 64'(fo_data), 64'd0);
    check({tag, "_fo_type"}, 64'(fo_type), 64'd0);
    check({tag, "_pl_rdy"}, 64'(pl_rdy), 64'd0);
    check({tag, "_req_rdy"}, 64'(req_rdy), 64'd1);
  endtask

  initial begin : main
    int base;
    int n;
    rst_n    = 1'b0;
    req_vld0 = 1'b0; req_x0 = '0; req_y0 = '0;
    req_vldf = 1'b0; req_xf = '0; req_yf = '0;

    // Reset with random inputs, then after release with idle inputs.
    repeat (3) begin
      req_vld = 1'($urandom); req_x = 4'($urandom); req_y = 4'($urandom);
      req_len = 4'($urandom); pl_vld = 1'($urandom); pl_data = $urandom;
      @(negedge clk);
      check_reset_outputs("rst");
    end
    req_vld = 1'b0;
    pl_vld  = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (2) begin
      @(negedge clk);
      check_reset_outputs("post_rst");
    end
    @(posedge clk);
    #1;

    // Single-flit packet from (5,5) to (12,3).
    send_req(4'd12, 4'd3, 4'd0, 32'h0002_1428);
    check("req_rdy_busy", 64'(req_rdy), 64'd0);
    @(posedge clk);
    #1;
    check("req_rdy_after", 64'(req_rdy), 64'd1);

    // Local destination and a west/north mix.
    send_req(4'd5, 4'd5, 4'd0, 32'h0000_1111);
    send_req(4'd0, 4'd9, 4'd0, 32'h0001_2122);
    drain(20);

    // Encoding extremes on the corner instances.
    req_x0 = 4'd15; req_y0 = 4'd15; req_vld0 = 1'b1;
    q0.push_back('{data: 32'h0000_8888, typ: 2'b11});
    req_xf = 4'd0;  req_yf = 4'd0;  req_vldf = 1'b1;
    qf.push_back('{data: 32'h0003_8888, typ: 2'b11});
    @(posedge clk);
    #1;
    req_vld0 = 1'b0;
    req_vldf = 1'b0;
    repeat (2) begin
      @(posedge clk);
      #1;
    end
    req_x0 = 4'd0; req_y0 = 4'd0; req_vld0 = 1'b1;
    q0.push_back('{data: 32'h0000_1111, typ: 2'b11});
    @(posedge clk);
    #1;
    req_vld0 = 1'b0;
    repeat (3) begin
      @(posedge clk);
      #1;
    end
    check("c0_drained", 64'(q0.size()), 64'd0);
    check("cf_drained", 64'(qf.size()), 64'd0);

    // Streaming: head + 3 payloads back-to-back, then one bubble.
    pop_cyc.delete();
    send_req(4'd9, 4'd1, 4'd3, 32'h0002_2121);
    send_pl(32'hAAAA_0001, 2'b00, 0);
    send_pl(32'hBBBB_0002, 2'b00, 0);
    send_pl(32'hCCCC_0003, 2'b01, 0);
    #1;
    check("pl_rdy_after_tail", 64'(pl_rdy), 64'd0);
    send_req(4'd5, 4'd5, 4'd0, 32'h0000_1111);
    drain(20);
    check("stream_pops", 64'(pop_cyc.size()), 64'd5);
    if (pop_cyc.size() == 5) begin
      check("stream_consecutive", 64'(pop_cyc[3] - pop_cyc[0]), 64'd3);
      check("stream_bubble", 64'(pop_cyc[4] - pop_cyc[3]), 64'd2);
    end

    // Backpressure: random fo_rdy and gapped payload.
    rdy_rand = 1'b1;
    send_req(4'd12, 4'd3, 4'd5, 32'h0002_1428);
    send_pl(32'hD000_0000, 2'b00, 1);
    send_pl(32'hD000_0001, 2'b00, 0);
    send_pl(32'hD000_0002, 2'b00, 3);
    send_pl(32'hD000_0003, 2'b00, 0);
    send_pl(32'hD000_0004, 2'b01, 2);
    drain(200);
    rdy_rand = 1'b0;
    repeat (2) begin
      @(posedge clk);
      #1;
    end

    // Reset mid-packet after two of four body flits.
    base = n_pop;
    send_req(4'd6, 4'd4, 4'd4, 32'h0002_1212);
    send_pl(32'hE000_0000, 2'b00, 0);
    send_pl(32'hE000_0001, 2'b00, 0);
    n = 0;
    while (n_pop < base + 3 && n < 50) begin
      @(posedge clk);
      #1;
      n++;
    end
    check("mid_pops", 64'(n_pop - base), 64'd3);
    #1;
    rst_n   = 1'b0;
    pl_vld  = 1'b1;
    pl_data = 32'hE000_0002;
    #1;
    check_reset_outputs("mid_rst");
    check("mid_rst_queue", 64'(q5.size()), 64'd0);
    @(negedge clk);
    check_reset_outputs("mid_rst_hold");
    pl_vld = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (3) begin
      @(negedge clk);
      check("no_tail_vld", 64'(fo_vld), 64'd0);
    end
    @(posedge clk);
    #1;
    send_req(4'd6, 4'd4, 4'd1, 32'h0002_1212);
    send_pl(32'h1234_5678, 2'b01, 0);
    drain(20);
    repeat (3) begin
      @(posedge clk);
      #1;
    end
    check("final_q5", 64'(q5.size()), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/noc_hdr_enc.md
# noc_hdr_enc

Source-side packet injector for the network interface of the SDM NoC. It converts an absolute destination coordinate into the relative, 1-of-4 digit-encoded XY hop address and direction bits that routers decrement one hop at a time. It emits the result as a head flit, then streams the payload flits behind it over a valid/ready flit port. It sits between the local core's request/payload ports and the router injection channel.

## Interface
- DW, 32: flit data width; must be ≥ 20.
- LX, 0: local X coordinate, 0..15.
- LY, 0: local Y coordinate, 0..15.
- clk  in  1  single clock; all state changes on the rising edge.
- rst_n  in  1  reset; asynchronous, active-low.
- req_vld  in  1  packet request valid.
- req_rdy  out  1  request accepted when req_vld && req_rdy at a clock edge.
- req_x  in  4  destination X coordinate, binary.
- req_y  in  4  destination Y coordinate, binary.
- req_len  in  4  number of payload flits, 0..15.
- pl_data  in  DW  payload flit.
- pl_vld  in  1  payload valid.
- pl_rdy  out  1  payload accepted when pl_vld && pl_rdy.
- fo_data  out  DW  flit output.
- fo_type  out  2  flit type: 2'b10 head, 2'b00 body, 2'b01 tail, 2'b11 head+tail.
- fo_vld  out  1  output flit valid.
- fo_rdy  in  1  output flit consumed when fo_vld && fo_rdy.

## Operation
- **Hop magnitude.** For each axis, mag = |dest − local| (0..15). The sign bit is 1 when dest < local.
- **Digit encoding.** mag is split into lo = mag%4 and hi = mag/4. The encoded byte is {onehot(hi), onehot(lo)}, where onehot(d) = 4'b1 << d. Examples: 0 → 8'h11, 5 → 8'h22, 6 → 8'h24, 15 → 8'h88.
- **Head flit layout.**
  - [7:0]: X byte.
  - [15:8]: Y byte.
  - [16]: X sign.
  - [17]: Y sign.
  - [DW-1:18]: zero.
- **Local destination.** dest == local yields X/Y bytes 8'h11 with both signs 0, and is legal.
- **FSM states.** IDLE, HEAD, BODY. A 4-bit counter `rem` holds the payload flits still to be loaded.
- **IDLE.**
  - req_rdy = 1, fo_vld = 0, pl_rdy = 0.
  - On request handshake: load the head into the output register, set fo_vld = 1 and rem = req_len, go to HEAD.
  - fo_type = 2'b11 if req_len == 0, else 2'b10.
- **HEAD.**
  - req_rdy = 0. pl_rdy = fo_rdy && rem != 0.
  - On fo_rdy: go to IDLE if rem == 0, else BODY.
  - A payload handshake in the same cycle loads the first payload flit with no bubble.
- **BODY.**
  - pl_rdy = (rem != 0) && (!fo_vld || fo_rdy).
  - Payload handshake: load pl_data into the output register, set fo_vld = 1, decrement rem. fo_type = 2'b01 if rem == 1, else 2'b00.
  - Output handshake with no new load: fo_vld = 0.
  - Tail handshake: go to IDLE.
- **Output register behaviour.**
  - fo_data and fo_type are held stable while fo_vld && !fo_rdy.
  - Flits are never dropped or duplicated.
- **Combinational path.** fo_rdy → pl_rdy is a permitted combinational path. All other outputs are registered or decoded from state only.
- **Payload gaps.** pl_vld low in BODY inserts bubbles (fo_vld = 0 once drained). It never corrupts the packet.
- **Reset.** Async assertion at any time, including mid-packet, abandons the packet and no tail is generated.
  - State returns to IDLE, rem = 0, fo_vld = 0, fo_data = 0, fo_type = 2'b00.
  - pl_rdy = 0 and req_rdy = 1.

## Timing
- Request accepted at edge k → head visible on fo_* after edge k (1-cycle latency).
- Payload accepted at edge k → flit visible after edge k.
- Throughput is one flit per cycle with fo_rdy held high.
- Tail consumed at edge t → IDLE after t. The earliest next request is accepted at edge t+1, its head is visible after t+1, and exactly one bubble cycle separates packets.
- A length-N packet with no stalls occupies N+1 consecutive output cycles.
- req_x, req_y and req_len are sampled only at the request handshake. They are don't-care otherwise.

## Test plan
- **Reset.** rst_n low with random inputs → fo_vld = 0, fo_data = 0, fo_type = 0, pl_rdy = 0, req_rdy = 1. The same values hold after release, until a request.
- **Single-flit packet.** LX = LY = 5, req_x = 12, req_y = 3, req_len = 0 → one flit after the accept edge: fo_type = 2'b11, fo_data = 32'h00021428. req_rdy is high again the cycle after consumption.
- **Encoding extremes.**
  - LX = LY = 0, dest (15,15) → fo_data = 32'h00008888.
  - LX = LY = 15, dest (0,0) → 32'h00038888.
  - dest == local → 32'h00001111.
- **Streaming.** req_len = 3, payload A, B, C back-to-back, fo_rdy = 1 → head, A/00, B/00, C/01 on four consecutive cycles. pl_rdy is low after C. One bubble precedes the next head.
- **Backpressure.** req_len = 5, fo_rdy toggled pseudo-randomly and pl_vld gapped → the output sequence exactly equals head + 5 payloads in order. fo_* is stable during stalls, and pl_rdy = 0 whenever fo_vld && !fo_rdy.
- **Reset mid-packet.** Assert rst_n after 2 of 4 body flits → outputs reach reset values immediately with no tail. The next request (len = 1) produces a clean head + tail.
